memdep_vio_queue: RTL and testbench

Buffers memory-order violation reports from the load pipes and feeds them to the store-set predictor as a single violation stream. Each training event is one `o_violation` pulse carrying one (store foldpc, load foldpc) pair. There is always at least one idle cycle between pulses, because the predictor's SSIT update pipeline cannot accept back-to-back violations. The block sits between the load/store violation checkers (upstream) and the store-set predictor (downstream). It removes duplicate reports and drops reports, with a count, when full.

---
 rtl/memdep_vio_queue.sv | 158 +++++++++++++++
 tb/tb_memdep_vio_queue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memdep_vio_queue.sv
// Violation report queue between the load-pipe violation checkers and the store-set predictor.
// Deduplicates reports, drops with a saturating count when full, and emits spaced training pulses.
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 16
`endif

module memdep_vio_queue #(
  parameter int unsigned LOAD_PIPES   = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FOLDPC_WIDTH = `MEMDEP_FOLDPC_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LOAD_PIPES-1:0]   i_vio_vld,
  input  logic [FOLDPC_WIDTH-1:0] i_vio_store_foldpc [LOAD_PIPES],
  input  logic [FOLDPC_WIDTH-1:0] i_vio_load_foldpc  [LOAD_PIPES],
  output logic                    o_violation,
  output logic [FOLDPC_WIDTH-1:0] o_vio_store_foldpc,
  output logic [FOLDPC_WIDTH-1:0] o_vio_load_foldpc,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [15:0]             o_drop_cnt
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned NW = $clog2(LOAD_PIPES + DEPTH + 1);

  typedef enum logic {ST_READY, ST_GAP} state_e;

  state_e                  state_q, state_d;
  logic [FOLDPC_WIDTH-1:0] mem_st_q [DEPTH];
  logic [FOLDPC_WIDTH-1:0] mem_ld_q [DEPTH];
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    viol_q, viol_d;
  logic [FOLDPC_WIDTH-1:0] out_st_q, out_st_d, out_ld_q, out_ld_d;
  logic [15:0]             drop_q, drop_d;

  logic [DEPTH-1:0]        ent_vld;
  logic [PW-1:0]           rel;
  logic [LOAD_PIPES-1:0]   wr_en;
  logic [PW-1:0]           wr_idx [LOAD_PIPES];
  logic [NW-1:0]           free_n, nsurv, nenq;
  logic                    dup;
  logic                    pop;

  // An entry is live when its distance from head is below the start-of-cycle count.
  always_comb begin
    rel = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      rel        = PW'(e) - head_q;
      ent_vld[e] = (CW'(rel) < count_q);
    end
  end

  // Survivors take free slots in ascending pipe order; a same-cycle pop frees nothing.
  always_comb begin
    wr_en  = '0;
    nsurv  = '0;
    nenq   = '0;
    dup    = 1'b0;
    drop_d = drop_q;
    free_n = NW'(DEPTH) - NW'(count_q);
    for (int unsigned p = 0; p < LOAD_PIPES; p++) begin
      wr_idx[p] = '0;
    end
    for (int unsigned p = 0; p < LOAD_PIPES; p++) begin
      dup = 1'b0;
      for (int unsigned q = 0; q < LOAD_PIPES; q++) begin
        if (q < p && i_vio_vld[q] &&
            i_vio_store_foldpc[q] == i_vio_store_foldpc[p] &&
            i_vio_load_foldpc[q]  == i_vio_load_foldpc[p]) begin
          dup = 1'b1;
        end
      end
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (ent_vld[e] && mem_st_q[e] == i_vio_store_foldpc[p] &&
            mem_ld_q[e] == i_vio_load_foldpc[p]) begin
          dup = 1'b1;
        end
      end
      if (i_vio_vld[p] && !dup) begin
        if (nsurv < free_n) begin
          wr_en[p]  = 1'b1;
          wr_idx[p] = tail_q + PW'(nsurv);
          nenq      = nenq + NW'(1);
        end else if (drop_d != '1) begin
          drop_d = drop_d + 16'd1;
        end
        nsurv = nsurv + NW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    viol_d   = 1'b0;
    out_st_d = out_st_q;
    out_ld_d = out_ld_q;
    head_d   = head_q;
    pop      = 1'b0;
    case (state_q)
      ST_READY: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          viol_d   = 1'b1;
          out_st_d = mem_st_q[head_q];
          out_ld_d = mem_ld_q[head_q];
          head_d   = head_q + PW'(1);
          state_d  = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_READY;
      default: state_d = ST_READY;
    endcase
    tail_d  = tail_q + PW'(nenq);
    count_d = count_q + CW'(nenq) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_READY;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      viol_q   <= 1'b0;
      out_st_q <= '0;
      out_ld_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      viol_q   <= viol_d;
      out_st_q <= out_st_d;
      out_ld_q <= out_ld_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < LOAD_PIPES; p++) begin
      if (wr_en[p]) begin
        mem_st_q[wr_idx[p]] <= i_vio_store_foldpc[p];
        mem_ld_q[wr_idx[p]] <= i_vio_load_foldpc[p];
      end
    end
  end

  assign o_violation        = viol_q;
  assign o_vio_store_foldpc = out_st_q;
  assign o_vio_load_foldpc  = out_ld_q;
  assign o_empty            = (count_q == '0);
  assign o_full             = (count_q == CW'(DEPTH));
  assign o_drop_cnt         = drop_q;

endmodule

// File: tb/tb_memdep_vio_queue.sv
// Self-checking bench for memdep_vio_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_memdep_vio_queue;
  localparam int unsigned NP = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW = 16;

  typedef struct packed { logic [FW-1:0] s; logic [FW-1:0] l; } pair_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NP-1:0] vld;
  logic [FW-1:0] st [NP];
  logic [FW-1:0] ld [NP];
  logic          o_violation, o_empty, o_full;
  logic [FW-1:0] o_vio_store_foldpc, o_vio_load_foldpc;
  logic [15:0]   o_drop_cnt;
  logic [50:0]   act;

  memdep_vio_queue #(.LOAD_PIPES(NP), .DEPTH(DEPTH), .FOLDPC_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .i_vio_vld(vld),
    .i_vio_store_foldpc(st), .i_vio_load_foldpc(ld),
    .o_violation(o_violation), .o_vio_store_foldpc(o_vio_store_foldpc),
    .o_vio_load_foldpc(o_vio_load_foldpc), .o_empty(o_empty), .o_full(o_full),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  assign act = {o_violation, o_vio_store_foldpc, o_vio_load_foldpc, o_empty, o_full, o_drop_cnt};
  localparam logic [50:0] RESET_VEC = {1'b0, 32'h0, 1'b1, 1'b0, 16'h0};

  pair_t       mq[$];
  bit          m_pulsed;
  pair_t       m_out;
  int unsigned m_drop, m_raw;
  int unsigned n_checks, n_fail;
  int unsigned uniq;

  function automatic logic [50:0] exp_vec();
    return {m_pulsed, m_out.s, m_out.l, mq.size() == 0, mq.size() == DEPTH, 16'(m_drop)};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_pulsed = 0;
    m_out = '0;
    m_drop = 0;
    m_raw = 0;
  endtask

  task automatic idle();
    vld = '0;
    for (int i = 0; i < NP; i++) begin st[i] = '0; ld[i] = '0; end
  endtask

  task automatic put(input int p, input logic [FW-1:0] s, input logic [FW-1:0] l);
    vld[p] = 1'b1; st[p] = s; ld[p] = l;
  endtask

  task automatic put_unique(input int p);
    put(p, uniq[15:0], 16'h8000 | uniq[31:16]);
    uniq++;
  endtask

  // Advance one clock and apply the queue rules to the model.
  task automatic tick();
    pair_t snap[$];
    pair_t cur;
    int unsigned free_n, nsurv;
    bit dup;
    @(posedge clk);
    snap = mq;
    free_n = DEPTH - mq.size();
    nsurv = 0;
    if (!m_pulsed && mq.size() > 0) begin
      m_out = mq.pop_front();
      m_pulsed = 1;
    end else begin
      m_pulsed = 0;
    end
    for (int p = 0; p < NP; p++) begin
      if (vld[p]) begin
        cur.s = st[p]; cur.l = ld[p];
        dup = 0;
        for (int q = 0; q < p; q++)
          if (vld[q] && st[q] == st[p] && ld[q] == ld[p]) dup = 1;
        foreach (snap[i]) if (snap[i] == cur) dup = 1;
        if (!dup) begin
          if (nsurv < free_n) mq.push_back(cur);
          else begin
            m_raw++;
            if (m_drop < 65535) m_drop++;
          end
          nsurv++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (act !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", act, RESET_VEC);
    end
  endtask

  task automatic test_single_latency();
    do_reset();
    put(0, 16'h12, 16'h34);
    tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL single_latency cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
      if (c == 1) begin
        n_checks++;
        if ({o_violation, o_vio_store_foldpc, o_vio_load_foldpc} !== {1'b1, 16'h12, 16'h34}) begin
          n_fail++; $display("FAIL single_pulse got=%b/%h/%h exp=1/0012/0034",
                             o_violation, o_vio_store_foldpc, o_vio_load_foldpc);
        end
      end
      tick();
    end
  endtask

  task automatic test_burst();
    logic prev_v;
    do_reset();
    put(0, 16'hA0, 16'hA1); put(1, 16'hB0, 16'hB1);
    tick();
    idle();
    put(0, 16'hC0, 16'hC1);
    prev_v = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL burst cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
      n_checks++;
      if (prev_v && o_violation) begin
        n_fail++; $display("FAIL burst_spacing cyc=%0d got=consecutive pulses exp=gap", c);
      end
      prev_v = o_violation;
      tick();
      idle();
    end
  endtask

  task automatic test_dedup();
    do_reset();
    put(0, 16'hE0, 16'hE1); put(1, 16'hF0, 16'hF1);
    tick();
    idle();
    put(0, 16'hD0, 16'hD1); put(1, 16'hD0, 16'hD1);
    tick();
    idle();
    put(1, 16'hD0, 16'hD1);
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL dedup cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
      tick();
      idle();
    end
    n_checks++;
    if (o_drop_cnt !== 16'd0) begin
      n_fail++; $display("FAIL dedup_drop got=%0d exp=0", o_drop_cnt);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      idle();
      if (c < 5) begin put_unique(0); put_unique(1); end
      tick();
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL overflow cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 28; c++) begin
      idle();
      if (c % 2 == 0 && c < 20) put_unique(c % 4 == 0 ? 0 : 1);
      tick();
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL wrap cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle();
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 2) != 0)
          put(p, 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
      tick();
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    int c;
    do_reset();
    c = 0;
    while (m_raw < 65537 + 8 && c < 60000) begin
      idle();
      put_unique(0); put_unique(1);
      tick();
      c++;
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL saturation cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
    end
    idle();
    n_checks++;
    if (m_raw < 65537) begin
      n_fail++; $display("FAIL saturation_budget got=%0d raw drops exp=65537", m_raw);
    end
    n_checks++;
    if (o_drop_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL saturation_value got=%h exp=ffff", o_drop_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    put(0, 16'h55, 16'h66);
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      idle();
      if (o_violation) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL async_reset_pulse got=no pulse exp=pulse within 6 cycles");
    end
    #3 rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (act !== RESET_VEC) begin
      n_fail++; $display("FAIL async_reset_immediate got=%h exp=%h", act, RESET_VEC);
    end
    #2 rst = 1'b1;
    put(0, 16'h77, 16'h88);
    tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL async_reset_after cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
      if (c == 1) begin
        n_checks++;
        if ({o_violation, o_vio_store_foldpc, o_vio_load_foldpc} !== {1'b1, 16'h77, 16'h88}) begin
          n_fail++; $display("FAIL async_reset_latency got=%b/%h/%h exp=1/0077/0088",
                             o_violation, o_vio_store_foldpc, o_vio_load_foldpc);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    uniq = 0;
    idle();
    test_reset();
    test_single_latency();
    test_burst();
    test_dedup();
    test_overflow();
    test_wrap();
    test_random();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
